// File: rtl/writeback_channel_native_pkg.sv
// Shared definitions for the cache back-end write channel: channel state encoding.
package writeback_channel_native_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } wb_state_e;

endpackage

// File: rtl/writeback_channel_native.sv
// Cache back-end write channel: captures one evicted line and bursts it to memory,
// one BE word per native valid/ready handshake.
module writeback_channel_native
   import writeback_channel_native_pkg::*;
#(
   parameter int FE_ADDR_W  = 32,
   parameter int FE_DATA_W  = 32,
   parameter int WORD_OFF_W = 3,
   parameter int BE_ADDR_W  = FE_ADDR_W,
   parameter int BE_DATA_W  = FE_DATA_W,
   parameter int BE_NBYTES  = BE_DATA_W/8,
   parameter int BE_BYTE_W  = $clog2(BE_NBYTES),
   parameter int LINE2MEM_W = WORD_OFF_W-$clog2(BE_DATA_W/FE_DATA_W)
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic                                      write_valid,
   input  logic [FE_ADDR_W-BE_BYTE_W-LINE2MEM_W-1:0] write_addr,
   input  logic [(BE_DATA_W<<LINE2MEM_W)-1:0]        write_wdata,
   output logic                                      write_ready,
   output logic                                      mem_valid,
   output logic [BE_ADDR_W-1:0]                      mem_addr,
   output logic [BE_DATA_W-1:0]                      mem_wdata,
   output logic [BE_NBYTES-1:0]                      mem_wstrb,
   input  logic                                      mem_ready
);

   localparam int LA_W = FE_ADDR_W-BE_BYTE_W-LINE2MEM_W;
   localparam int NW   = 1 << LINE2MEM_W;

   wb_state_e                    state;
   logic [LA_W-1:0]              line_addr;
   logic [NW-1:0][BE_DATA_W-1:0] line_buf;
   logic                         last_word;
   logic [FE_ADDR_W-1:0]         addr_full;

   assign mem_valid   = (state == ST_WRITE);
   assign write_ready = (state == ST_IDLE);
   assign mem_wstrb   = {BE_NBYTES{mem_valid}};

   // The line is buffered at accept so the source is free to reuse write_wdata immediately.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_IDLE;
         line_addr <= '0;
         line_buf  <= '0;
      end else begin
         case (state)
            ST_IDLE:
               if (write_valid) begin
                  line_addr <= write_addr;
                  line_buf  <= write_wdata;
                  state     <= ST_WRITE;
               end
            ST_WRITE:
               if (mem_ready && last_word) state <= ST_IDLE;
            default:
               state <= ST_IDLE;
         endcase
      end
   end

   generate
      if (LINE2MEM_W > 0) begin : g_cnt
         logic [LINE2MEM_W-1:0] word_cnt;

         always_ff @(posedge clk) begin
            if (!reset)
               word_cnt <= '0;
            else if (state == ST_IDLE) begin
               if (write_valid) word_cnt <= '0;
            end else if (mem_ready)
               word_cnt <= word_cnt + 1'b1;
         end

         assign last_word = &word_cnt;
         assign mem_wdata = line_buf[word_cnt];
         assign addr_full = {line_addr, word_cnt, {BE_BYTE_W{1'b0}}};
      end else begin : g_nocnt
         assign last_word = 1'b1;
         assign mem_wdata = line_buf[0];
         assign addr_full = {line_addr, {BE_BYTE_W{1'b0}}};
      end

      if (BE_ADDR_W > FE_ADDR_W) begin : g_addr_ext
         assign mem_addr = {{(BE_ADDR_W-FE_ADDR_W){1'b0}}, addr_full};
      end else begin : g_addr_fit
         assign mem_addr = addr_full[BE_ADDR_W-1:0];
      end
   endgenerate

endmodule

// File: tb/tb_writeback_channel_native.sv
// Bench for writeback_channel_native: 8-word default build plus a single-word (LINE2MEM_W=0) build.
module tb_writeback_channel_native;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // default build: 8 words/line
   logic         write_valid, write_ready, mem_valid, mem_ready;
   logic [26:0]  write_addr;
   logic [255:0] write_wdata;
   logic [31:0]  mem_addr, mem_wdata;
   logic [3:0]   mem_wstrb;

   // single-word build
   logic         write_valid0, write_ready0, mem_valid0, mem_ready0;
   logic [29:0]  write_addr0;
   logic [31:0]  write_wdata0;
   logic [31:0]  mem_addr0, mem_wdata0;
   logic [3:0]   mem_wstrb0;

   int checks = 0;
   int errors = 0;

   writeback_channel_native u_dut (
      .clk(clk), .reset(reset),
      .write_valid(write_valid), .write_addr(write_addr), .write_wdata(write_wdata),
      .write_ready(write_ready),
      .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ready(mem_ready)
   );

   writeback_channel_native #(.WORD_OFF_W(0)) u_dut0 (
      .clk(clk), .reset(reset),
      .write_valid(write_valid0), .write_addr(write_addr0), .write_wdata(write_wdata0),
      .write_ready(write_ready0),
      .mem_valid(mem_valid0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
      .mem_wstrb(mem_wstrb0), .mem_ready(mem_ready0)
   );

   // Reference: word k of line a lives at byte address a*32 + k*4.
   function automatic logic [31:0] exp_addr(input logic [26:0] a, input int k);
      return 32'(a) * 32 + 32'(k) * 4;
   endfunction

   function automatic logic [255:0] rand_line();
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   // Sends one line; stalls word stall_word for stall_n cycles, plus random stalls at stall_pct.
   task automatic send_line(input string name, input logic [26:0] a, input logic [255:0] line,
                            input int stall_pct, input int stall_word, input int stall_n,
                            input bit poke, output int cycles);
      int k, stalled;
      bit rdy;
      write_addr  = a;
      write_wdata = line;
      write_valid = 1'b1;
      mem_ready   = 1'($urandom_range(1));
      @(negedge clk);
      checks++;
      if (write_ready !== 1'b1 || mem_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s accept: write_ready=%b mem_valid=%b required 1/0", name, write_ready, mem_valid);
      end
      next_cycle();
      write_valid = 1'b0;
      write_wdata = rand_line();
      write_addr  = 27'($urandom);
      k = 0; cycles = 0; stalled = 0;
      while (k < 8 && cycles < 200) begin
         if (k == stall_word && stalled < stall_n) begin
            rdy = 1'b0; stalled++;
         end else
            rdy = ($urandom_range(99) >= stall_pct);
         mem_ready = rdy;
         if (poke) begin
            write_valid = 1'($urandom_range(1));
            write_addr  = 27'h456;
         end
         @(negedge clk);
         checks++;
         if (mem_valid !== 1'b1 || write_ready !== 1'b0 || mem_wstrb !== 4'hF) begin
            errors++;
            $display("FAIL %s beat%0d ctrl: valid=%b ready=%b wstrb=%h required 1/0/f",
                     name, k, mem_valid, write_ready, mem_wstrb);
         end
         checks++;
         if (mem_addr !== exp_addr(a, k) || mem_wdata !== line[k*32 +: 32]) begin
            errors++;
            $display("FAIL %s beat%0d: addr=%h data=%h required %h/%h",
                     name, k, mem_addr, mem_wdata, exp_addr(a, k), line[k*32 +: 32]);
         end
         cycles++;
         next_cycle();
         if (rdy) k++;
      end
      mem_ready   = 1'b0;
      write_valid = 1'b0;
      checks++;
      if (k != 8) begin
         errors++;
         $display("FAIL %s timeout: words=%0d required 8", name, k);
      end
      @(negedge clk);
      checks++;
      if (mem_valid !== 1'b0 || write_ready !== 1'b1 || mem_wstrb !== 4'h0) begin
         errors++;
         $display("FAIL %s return: valid=%b ready=%b wstrb=%h required 0/1/0",
                  name, mem_valid, write_ready, mem_wstrb);
      end
      next_cycle();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      write_valid = 1'b0; mem_ready = 1'b0; write_addr = '0; write_wdata = '0;
      write_valid0 = 1'b0; mem_ready0 = 1'b0; write_addr0 = '0; write_wdata0 = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (mem_valid !== 1'b0 || write_ready !== 1'b1 || mem_wstrb !== 4'h0) begin
            errors++;
            $display("FAIL reset%0d: valid=%b ready=%b wstrb=%h required 0/1/0",
                     i, mem_valid, write_ready, mem_wstrb);
         end
         checks++;
         if (mem_valid0 !== 1'b0 || write_ready0 !== 1'b1 || mem_wstrb0 !== 4'h0) begin
            errors++;
            $display("FAIL reset0_%0d: valid=%b ready=%b wstrb=%h required 0/1/0",
                     i, mem_valid0, write_ready0, mem_wstrb0);
         end
      end
      next_cycle();
   endtask

   task automatic test_full_speed();
      logic [255:0] l;
      int cyc;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'hA000_0000 | 32'(i);
      send_line("full_speed", 27'h123, l, 0, -1, 0, 1'b0, cyc);
      checks++;
      if (cyc != 8) begin
         errors++;
         $display("FAIL full_speed cycles: got %0d required 8", cyc);
      end
      checks++;
      if (exp_addr(27'h123, 0) !== 32'h2460) begin
         errors++;
         $display("FAIL model_base: got %h required 2460", exp_addr(27'h123, 0));
      end
   endtask

   task automatic test_backpressure();
      logic [255:0] l;
      int cyc;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'hA000_0000 | 32'(i);
      send_line("backpressure", 27'h123, l, 0, 2, 3, 1'b0, cyc);
      checks++;
      if (cyc != 11) begin
         errors++;
         $display("FAIL backpressure cycles: got %0d required 11", cyc);
      end
   endtask

   task automatic test_busy_reject();
      int cyc;
      send_line("busy_reject", 27'h123, rand_line(), 20, -1, 0, 1'b1, cyc);
      send_line("after_reject", 27'h456, rand_line(), 0, -1, 0, 1'b0, cyc);
   endtask

   task automatic test_random();
      int cyc;
      for (int n = 0; n < 20; n++)
         send_line("random", 27'($urandom), rand_line(), $urandom_range(60), -1, 0, 1'($urandom_range(1)), cyc);
   endtask

   task automatic test_reset_mid_burst();
      logic [255:0] l;
      int cyc;
      l = rand_line();
      write_addr = 27'h123; write_wdata = l; write_valid = 1'b1; mem_ready = 1'b0;
      next_cycle();
      write_valid = 1'b0;
      mem_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (k == 4) reset = 1'b0;
         @(negedge clk);
         checks++;
         if (mem_valid !== 1'b1 || mem_addr !== exp_addr(27'h123, k)) begin
            errors++;
            $display("FAIL midreset beat%0d: valid=%b addr=%h required 1/%h",
                     k, mem_valid, mem_addr, exp_addr(27'h123, k));
         end
         next_cycle();
      end
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (mem_valid !== 1'b0 || write_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset idle%0d: valid=%b ready=%b addr=%h required 0/1",
                     i, mem_valid, write_ready, mem_addr);
         end
         next_cycle();
      end
      mem_ready = 1'b0;
      send_line("after_midreset", 27'h7A5, rand_line(), 30, -1, 0, 1'b0, cyc);
   endtask

   task automatic test_single_word();
      logic [29:0] a;
      logic [31:0] d;
      for (int n = 0; n < 6; n++) begin
         a = (n == 0) ? 30'h10 : 30'($urandom);
         d = $urandom;
         write_addr0 = a; write_wdata0 = d; write_valid0 = 1'b1; mem_ready0 = 1'b1;
         next_cycle();
         write_valid0 = 1'b0; write_wdata0 = ~d; mem_ready0 = 1'b0;
         for (int w = 0; w < 2; w++) begin
            if (w == 1) mem_ready0 = 1'b1;
            @(negedge clk);
            checks++;
            if (mem_valid0 !== 1'b1 || write_ready0 !== 1'b0 || mem_wstrb0 !== 4'hF ||
                mem_addr0 !== {a, 2'b00} || mem_wdata0 !== d) begin
               errors++;
               $display("FAIL single%0d w%0d: valid=%b ready=%b wstrb=%h addr=%h data=%h required 1/0/f/%h/%h",
                        n, w, mem_valid0, write_ready0, mem_wstrb0, mem_addr0, mem_wdata0, {a, 2'b00}, d);
            end
            next_cycle();
         end
         mem_ready0 = 1'b0;
         @(negedge clk);
         checks++;
         if (mem_valid0 !== 1'b0 || write_ready0 !== 1'b1 || mem_wstrb0 !== 4'h0) begin
            errors++;
            $display("FAIL single%0d idle: valid=%b ready=%b wstrb=%h required 0/1/0",
                     n, mem_valid0, write_ready0, mem_wstrb0);
         end
         checks++;
         if (n == 0 && mem_addr0 !== 32'h40) begin
            errors++;
            $display("FAIL single_addr: got %h required 40", mem_addr0);
         end
         next_cycle();
      end
   endtask

   initial begin
      test_reset();
      test_full_speed();
      test_backpressure();
      test_busy_reject();
      test_random();
      test_reset_mid_burst();
      test_single_word();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
